// File: rtl/rib_timer_pkg.sv
// Shared constants for the RIB timer slave.
// Register offsets and bit positions.
package rib_timer_pkg;

    localparam logic [7:0] TMR_CTRL   = 8'h00;
    localparam logic [7:0] TMR_COUNT  = 8'h04;
    localparam logic [7:0] TMR_CMP    = 8'h08;
    localparam logic [7:0] TMR_STATUS = 8'h0C;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_IE        = 1;
    localparam int CTRL_AUTO      = 2;
    localparam int CTRL_PRESC_LSB = 8;

    localparam int STAT_PEND = 0;
    localparam int STAT_OVF  = 1;

endpackage

// File: rtl/rib_timer_presc.sv
// Prescaler for the RIB timer.
// Emits one tick every presc+1 enabled cycles.
module rib_timer_presc #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               restart,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt;

    // >= keeps the divider from running away if presc shrinks mid-count
    assign tick = en && (cnt >= presc);

    // divider counter, held at zero while disabled or restarting
    always_ff @(posedge clk) begin
        if (rst || !en || restart) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/rib_timer_slave.sv
// Memory-mapped timer on the RIB slave side.
// Registers, compare match, read mux and level interrupt.
module rib_timer_slave
    import rib_timer_pkg::*;
#(
    parameter int          PRESC_W   = 8,
    parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        int_o
);

    logic               en;
    logic               ie;
    logic               auto_rl;
    logic [PRESC_W-1:0] presc;
    logic [31:0]        count;
    logic [31:0]        compare;
    logic               pend;
    logic               ovf;

    logic [7:0]  off;
    logic        wr;
    logic        wr_ctrl;
    logic        wr_count;
    logic        wr_cmp;
    logic        wr_stat;
    logic        tick;
    logic        eff_tick;
    logic        match;
    logic        restart;
    logic [31:0] ctrl_rd;
    logic        unused_addr;

    assign off      = {addr_i[7:2], 2'b00};
    assign wr       = req_i && we_i;
    assign wr_ctrl  = wr && (off == TMR_CTRL);
    assign wr_count = wr && (off == TMR_COUNT);
    assign wr_cmp   = wr && (off == TMR_CMP);
    assign wr_stat  = wr && (off == TMR_STATUS);

    assign restart  = wr_ctrl && data_i[CTRL_EN] && !en;

    // a COUNT write on a tick cycle swallows that tick entirely
    assign eff_tick = tick && !wr_count;
    assign match    = eff_tick && (count == compare);

    assign int_o       = pend && ie;
    assign unused_addr = ^{addr_i[31:8], addr_i[1:0]};

    rib_timer_presc #(
        .PRESC_W(PRESC_W)
    ) u_presc (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .restart(restart),
        .presc  (presc),
        .tick   (tick)
    );

    // CTRL: software write beats the one-shot enable clear
    always_ff @(posedge clk) begin
        if (rst) begin
            en      <= 1'b0;
            ie      <= 1'b0;
            auto_rl <= 1'b0;
            presc   <= '0;
        end else if (wr_ctrl) begin
            en      <= data_i[CTRL_EN];
            ie      <= data_i[CTRL_IE];
            auto_rl <= data_i[CTRL_AUTO];
            presc   <= data_i[CTRL_PRESC_LSB +: PRESC_W];
        end else if (match && !auto_rl) begin
            en      <= 1'b0;
        end
    end

    // COUNT and COMPARE registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            compare <= CMP_RESET;
        end else begin
            if (wr_count) begin
                count <= data_i;
            end else if (eff_tick) begin
                count <= match ? 32'd0 : count + 32'd1;
            end
            if (wr_cmp) begin
                compare <= data_i;
            end
        end
    end

    // STATUS: W1C, with a same-cycle set taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            pend <= match ||
                    (pend && !(wr_stat && data_i[STAT_PEND]));
            ovf  <= (match && pend) ||
                    (ovf && !(wr_stat && data_i[STAT_OVF]));
        end
    end

    // CTRL readback image with unused bits forced low
    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_EN]   = en;
        ctrl_rd[CTRL_IE]   = ie;
        ctrl_rd[CTRL_AUTO] = auto_rl;
        ctrl_rd[CTRL_PRESC_LSB +: PRESC_W] = presc;
    end

    // zero-latency read mux, idle bus reads zero
    always_comb begin
        data_o = '0;
        if (req_i && !we_i) begin
            case (off)
                TMR_CTRL:   data_o = ctrl_rd;
                TMR_COUNT:  data_o = count;
                TMR_CMP:    data_o = compare;
                TMR_STATUS: data_o = {30'd0, ovf, pend};
                default:    data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_rib_timer_slave.sv
// Scoreboard bench for rib_timer_slave.
// Reference model predicts every read; monitor compares.
module tb_rib_timer_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        int_o;

    always #5 clk = ~clk;

    rib_timer_slave #(
        .PRESC_W  (8),
        .CMP_RESET(32'hFFFF_FFFF)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req_i (req_i),
        .we_i  (we_i),
        .addr_i(addr_i),
        .data_i(data_i),
        .data_o(data_o),
        .int_o (int_o)
    );

    typedef struct {
        logic [31:0] data;
        logic        intr;
        logic [7:0]  addr;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // reference model state
    bit          m_en, m_ie, m_auto;
    int          m_presc;
    int          m_phase;
    logic [31:0] m_count, m_cmp;
    bit          m_pend, m_ovf;

    function automatic void m_reset();
        m_en = 0; m_ie = 0; m_auto = 0;
        m_presc = 0; m_phase = 0;
        m_count = 0; m_cmp = 32'hFFFF_FFFF;
        m_pend = 0; m_ovf = 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        logic [31:0] v;
        v = 0;
        case (a & 8'hFC)
            8'h00: begin
                v[0] = m_en; v[1] = m_ie; v[2] = m_auto;
                v[15:8] = m_presc[7:0];
            end
            8'h04: v = m_count;
            8'h08: v = m_cmp;
            8'h0C: begin v[0] = m_pend; v[1] = m_ovf; end
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic void m_step(input bit rq, input bit w,
                                   input logic [31:0] a,
                                   input logic [31:0] d);
        bit          wrq, w_ctrl, w_cnt, w_cmp, w_st, tick, hit;
        logic [7:0]  o;
        logic [31:0] n_count;
        bit          n_en, n_pend, n_ovf;
        int          n_phase;
        o      = a[7:0] & 8'hFC;
        wrq    = rq && w;
        w_ctrl = wrq && o == 8'h00;
        w_cnt  = wrq && o == 8'h04;
        w_cmp  = wrq && o == 8'h08;
        w_st   = wrq && o == 8'h0C;
        tick   = m_en && (m_phase >= m_presc);
        hit    = tick && !w_cnt && (m_count == m_cmp);
        if (w_cnt) n_count = d;
        else if (hit) n_count = 0;
        else if (tick) n_count = m_count + 1;
        else n_count = m_count;
        n_pend = hit || (m_pend && !(w_st && d[0]));
        n_ovf  = (hit && m_pend) || (m_ovf && !(w_st && d[1]));
        if (!m_en || tick) n_phase = 0;
        else n_phase = m_phase + 1;
        n_en = m_en;
        if (hit && !m_auto) n_en = 0;
        if (w_ctrl) begin
            n_en = d[0]; m_ie = d[1]; m_auto = d[2];
            m_presc = int'(d[15:8]);
        end
        if (w_cmp) m_cmp = d;
        m_en = n_en; m_count = n_count; m_phase = n_phase;
        m_pend = n_pend; m_ovf = n_ovf;
    endfunction

    task automatic cyc(input logic r, input logic rq, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        rst = r; req_i = rq; we_i = w; addr_i = a; data_i = d;
        if (!r && rq && !w) begin
            e.data = m_read(a[7:0]);
            e.intr = m_pend && m_ie;
            e.addr = a[7:0];
            sbq.push_back(e);
        end
        @(posedge clk);
        if (r) m_reset();
        else m_step(rq, w, a, d);
        #1;
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1'b0, 1'b1, 1'b0, a, $urandom);
    endtask

    task automatic wrt(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b1, a, d);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, $urandom_range(0, 1), $urandom, $urandom);
    endtask

    task automatic do_rst();
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    // monitor: compare whatever the DUT presents against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0) begin
            if (req_i && !we_i) begin
                if (sbq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_read got=%h", data_o);
                end else begin
                    e = sbq.pop_front();
                    n_chk++;
                    if (data_o !== e.data) begin
                        n_fail++;
                        $display("FAIL rd_data off=%h got=%h exp=%h",
                                 e.addr, data_o, e.data);
                    end
                    n_chk++;
                    if (int_o !== e.intr) begin
                        n_fail++;
                        $display("FAIL int_o off=%h got=%b exp=%b",
                                 e.addr, int_o, e.intr);
                    end
                end
            end else if (!req_i) begin
                n_chk++;
                if (data_o !== 32'd0) begin
                    n_fail++;
                    $display("FAIL idle_data got=%h exp=0", data_o);
                end
            end
        end
    end

    function automatic logic [31:0] pick_addr();
        logic [31:0] r;
        logic [7:0]  o;
        int          s;
        r = $urandom;
        s = $urandom_range(0, 9);
        case (s)
            0, 1, 2: o = 8'h00;
            3, 4:    o = 8'h04;
            5, 6:    o = 8'h08;
            7, 8:    o = 8'h0C;
            default: o = 8'h10 + 8'($urandom_range(0, 59) * 4);
        endcase
        return {r[31:8], o[7:2], r[1:0]};
    endfunction

    initial begin
        logic [31:0] a, d;
        int          k;
        m_reset();
        rst = 1; req_i = 0; we_i = 0; addr_i = 0; data_i = 0;
        do_rst(); do_rst();

        // reset values, including unmapped offsets
        rd(32'h00); rd(32'h04); rd(32'h08); rd(32'h0C);
        rd(32'h10); rd(32'hFFFF_FF23);

        // auto-reload, PRESC=0, compare 3, OVF on second match
        wrt(32'h08, 3); wrt(32'h00, 32'h7);
        repeat (6) begin rd(32'h04); rd(32'h0C); end

        // one-shot, PRESC=3, compare 2
        do_rst();
        wrt(32'h08, 2); wrt(32'h00, 32'h0303);
        repeat (20) begin rd(32'h04); rd(32'h00); end

        // W1C of PEND, then W1C racing matches
        do_rst();
        wrt(32'h08, 1); wrt(32'h00, 32'h3);
        rd(32'h04); rd(32'h0C); rd(32'h0C);
        wrt(32'h0C, 1); rd(32'h0C);
        wrt(32'h08, 3); wrt(32'h00, 32'h7);
        repeat (8) begin wrt(32'h0C, 3); rd(32'h0C); end

        // 32-bit wrap without a flag
        do_rst();
        wrt(32'h08, 5); wrt(32'h04, 32'hFFFF_FFFE); wrt(32'h00, 1);
        repeat (4) rd(32'h04);
        rd(32'h0C);

        // COUNT write on a tick, then reset mid-count with IRQ up
        do_rst();
        wrt(32'h08, 2); wrt(32'h00, 32'h7);
        rd(32'h04); rd(32'h04);
        wrt(32'h04, 100);
        rd(32'h04); rd(32'h04);
        wrt(32'h04, 2); rd(32'h0C); rd(32'h0C);
        do_rst();
        rd(32'h00); rd(32'h04); rd(32'h08); rd(32'h0C);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 199);
            a = pick_addr();
            if (k < 2) begin
                do_rst();
            end else if (k < 20) begin
                idle();
            end else if (k < 110) begin
                rd(a);
            end else begin
                d = $urandom;
                case ({a[7:2], 2'b00})
                    8'h00: begin
                        d[15:8] = 8'($urandom_range(0, 3));
                        if ($urandom_range(0, 2) != 0) d[0] = 1'b1;
                    end
                    8'h04: d = ($urandom_range(0, 1) != 0)
                               ? 32'($urandom_range(0, 10))
                               : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                    8'h08: d = 32'($urandom_range(0, 12));
                    default: ;
                endcase
                wrt(a, d);
            end
        end

        idle(); idle();
        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain left=%0d exp=0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
